// File: rtl/div_pkg.sv
// Shared state, error-code and helper definitions for param_divider.
// DIV_RADIX4_EN switches the iteration datapath to two quotient bits per edge.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CHECK,
    DIV_ITER,
    DIV_FIX
  } div_state_t;

  localparam logic [1:0] DIV_ERR_NONE = 2'b00;
  localparam logic [1:0] DIV_ERR_ZERO = 2'b01;
  localparam logic [1:0] DIV_ERR_OVF  = 2'b10;

  // Widest operand the negate helper handles (2*WIDTH must fit).
  localparam int DIV_MAX_W = 64;

`ifdef DIV_RADIX4_EN
  localparam int DIV_BPS = 2;
`else
  localparam int DIV_BPS = 1;
`endif

  function automatic logic [DIV_MAX_W-1:0] div_neg(input logic [DIV_MAX_W-1:0] v,
                                                   input int                   n);
    logic [DIV_MAX_W-1:0] mask;
    mask = (n >= DIV_MAX_W) ? '1 : ((DIV_MAX_W'(1) << n) - DIV_MAX_W'(1));
    return (~v + DIV_MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/param_divider_if.sv
// Request/result bundle between a CPU execute stage (master) and param_divider (slave).
interface param_divider_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 flush;
  logic                 is_half;
  logic                 is_signed;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 complete;
  logic                 error;
  logic [1:0]           error_code;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;

  modport master (
    output start, flush, is_half, is_signed, dividend, divisor,
    input  busy, complete, error, error_code, quotient, remainder
  );

  modport slave (
    input  start, flush, is_half, is_signed, dividend, divisor,
    output busy, complete, error, error_code, quotient, remainder
  );
endinterface

// File: rtl/div_step.sv
// Combinational restoring-division step: shifts in DIV_BPS dividend bits and
// retires DIV_BPS quotient bits (radix-4 when DIV_RADIX4_EN is defined).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   rem_i,
  input  logic [WIDTH-1:0]   div_i,
  input  logic [DIV_BPS-1:0] bits_i,
  output logic [WIDTH-1:0]   rem_o,
  output logic [DIV_BPS-1:0] q_o
);

`ifdef DIV_RADIX4_EN
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] d1;
  logic [WIDTH+1:0] d2;
  logic [WIDTH+1:0] d3;
  logic [WIDTH+1:0] sub;

  assign trial = {rem_i, bits_i};
  assign d1    = {2'b00, div_i};
  assign d2    = {1'b0, div_i, 1'b0};
  assign d3    = d1 + d2;

  // rem_i < div_i guarantees trial < 4*div_i, so one of the four digits fits.
  always_comb begin
    q_o = 2'd0;
    sub = '0;
    if (trial >= d3) begin
      q_o = 2'd3;
      sub = d3;
    end else if (trial >= d2) begin
      q_o = 2'd2;
      sub = d2;
    end else if (trial >= d1) begin
      q_o = 2'd1;
      sub = d1;
    end
  end

  assign rem_o = WIDTH'(trial - sub);
`else
  logic [WIDTH:0] trial;
  logic [WIDTH:0] dext;
  logic           ge;

  assign trial = {rem_i, bits_i};
  assign dext  = {1'b0, div_i};
  assign ge    = (trial >= dext);
  assign q_o   = ge;
  assign rem_o = WIDTH'(ge ? (trial - dext) : trial);
`endif

endmodule

// File: rtl/param_divider.sv
// Sequential 2N/N -> N divider (N = WIDTH or WIDTH/2), unsigned or truncating signed.
// Optional DIV_RADIX4_EN halves the iteration count. WIDTH must be <= 32.
module param_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  param_divider_if.slave bus
);

  localparam int HW    = WIDTH / 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t         state_q, state_d;
  logic               busy_q, busy_d;
  logic               complete_q, complete_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               half_q, half_d;
  logic               signed_q, signed_d;
  logic               sd_q, sd_d;
  logic               sv_q, sv_d;
  logic [2*WIDTH-1:0] dvd_mag_q, dvd_mag_d;
  logic [WIDTH-1:0]   dsr_mag_q, dsr_mag_d;
  logic [WIDTH-1:0]   prem_q, prem_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0]   dsr_in;
  logic               dvd_sign;
  logic               dsr_sign;
  logic [WIDTH-1:0]   chk_hi;
  logic [WIDTH-1:0]   chk_lo;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   q_top;
  logic               q_neg;
  logic               q_ovf;
  logic [WIDTH-1:0]   step_rem;
  logic [DIV_BPS-1:0] step_q;

  function automatic logic [WIDTH-1:0] neg_n(input logic [WIDTH-1:0] v, input logic half);
    return WIDTH'(div_neg(DIV_MAX_W'(v), half ? HW : WIDTH));
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2n(input logic [2*WIDTH-1:0] v, input logic half);
    return (2*WIDTH)'(div_neg(DIV_MAX_W'(v), half ? WIDTH : 2*WIDTH));
  endfunction

  assign dvd_in   = bus.is_half ? {{WIDTH{1'b0}}, bus.dividend[WIDTH-1:0]} : bus.dividend;
  assign dsr_in   = bus.is_half ? {{HW{1'b0}}, bus.divisor[HW-1:0]} : bus.divisor;
  assign dvd_sign = bus.is_signed & (bus.is_half ? bus.dividend[WIDTH-1] : bus.dividend[2*WIDTH-1]);
  assign dsr_sign = bus.is_signed & (bus.is_half ? bus.divisor[HW-1] : bus.divisor[WIDTH-1]);

  // Half mode left-aligns the low dividend bits so the step always reads the MSB.
  assign chk_hi = half_q ? {{HW{1'b0}}, dvd_mag_q[WIDTH-1:HW]} : dvd_mag_q[2*WIDTH-1:WIDTH];
  assign chk_lo = half_q ? {dvd_mag_q[HW-1:0], {HW{1'b0}}} : dvd_mag_q[WIDTH-1:0];

  assign q_mag = half_q ? {{HW{1'b0}}, lo_q[HW-1:0]} : lo_q;
  assign q_top = half_q ? (WIDTH'(1) << (HW - 1)) : (WIDTH'(1) << (WIDTH - 1));
  assign q_neg = signed_q & (sd_q ^ sv_q);
  assign q_ovf = signed_q & (q_neg ? (q_mag > q_top) : (q_mag >= q_top));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (prem_q),
    .div_i  (dsr_mag_q),
    .bits_i (lo_q[WIDTH-1 -: DIV_BPS]),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    complete_d = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    quot_d     = quot_q;
    rmd_d      = rmd_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    signed_d   = signed_q;
    sd_d       = sd_q;
    sv_d       = sv_q;
    dvd_mag_d  = dvd_mag_q;
    dsr_mag_d  = dsr_mag_q;
    prem_d     = prem_q;
    lo_d       = lo_q;

    if (bus.flush) begin
      state_d = DIV_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (bus.start) begin
            half_d     = bus.is_half;
            signed_d   = bus.is_signed;
            sd_d       = dvd_sign;
            sv_d       = dsr_sign;
            dvd_mag_d  = dvd_sign ? neg_2n(dvd_in, bus.is_half) : dvd_in;
            dsr_mag_d  = dsr_sign ? neg_n(dsr_in, bus.is_half) : dsr_in;
            err_code_d = DIV_ERR_NONE;
            busy_d     = 1'b1;
            state_d    = DIV_CHECK;
          end
        end
        DIV_CHECK: begin
          if (dsr_mag_q == '0) begin
            error_d    = 1'b1;
            err_code_d = DIV_ERR_ZERO;
            busy_d     = 1'b0;
            state_d    = DIV_IDLE;
          end else if (chk_hi >= dsr_mag_q) begin
            error_d    = 1'b1;
            err_code_d = DIV_ERR_OVF;
            busy_d     = 1'b0;
            state_d    = DIV_IDLE;
          end else begin
            prem_d  = chk_hi;
            lo_d    = chk_lo;
            cnt_d   = half_q ? CNT_W'(HW / DIV_BPS) : CNT_W'(WIDTH / DIV_BPS);
            state_d = DIV_ITER;
          end
        end
        DIV_ITER: begin
          prem_d = step_rem;
          lo_d   = {lo_q[WIDTH-DIV_BPS-1:0], step_q};
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DIV_FIX;
          end
        end
        DIV_FIX: begin
          busy_d  = 1'b0;
          state_d = DIV_IDLE;
          if (q_ovf) begin
            error_d    = 1'b1;
            err_code_d = DIV_ERR_OVF;
          end else begin
            complete_d = 1'b1;
            quot_d     = q_neg ? neg_n(q_mag, half_q) : q_mag;
            rmd_d      = (signed_q & sd_q) ? neg_n(prem_q, half_q) : prem_q;
          end
        end
        default: begin
          state_d = DIV_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= DIV_IDLE;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= DIV_ERR_NONE;
      quot_q     <= '0;
      rmd_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      quot_q     <= quot_d;
      rmd_q      <= rmd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    half_q    <= half_d;
    signed_q  <= signed_d;
    sd_q      <= sd_d;
    sv_q      <= sv_d;
    dvd_mag_q <= dvd_mag_d;
    dsr_mag_q <= dsr_mag_d;
    prem_q    <= prem_d;
    lo_q      <= lo_d;
  end

  assign bus.busy       = busy_q;
  assign bus.complete   = complete_q;
  assign bus.error      = error_q;
  assign bus.error_code = err_code_q;
  assign bus.quotient   = quot_q;
  assign bus.remainder  = rmd_q;

endmodule
